cordic_element_serial: RTL

- Parametrised, digit-serial CORDIC micro-rotation stage. Successor to the fixed 2-bit/12-bit stage.
- Deserialises X/Y/A words LSB-digit first and performs one shift-add iteration selected by `stg`. Supports rotation or vectoring mode.
- Re-serialises the result through a double-buffered output so a new frame can load while the previous one shifts out.
- Instances are chained in the NCO / CORDIC pipeline between the angle front end and the output terminal.

---
 rtl/cordic_pkg.sv | 37 +++
 rtl/cordic_digit_sipo_piso.sv | 62 ++++++
 rtl/cordic_element_serial.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: constants shared by the digit-serial CORDIC stage.
// Latency: n/a (package only).
// Backpressure: n/a; angle scale is 180 degrees = 32768 at 16 bits.
package cordic_pkg;

  // Mode encoding on the mode input
  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // CORDIC gain compensation 1/K at 16-bit scale; narrower words shift it down
  localparam logic signed [15:0] ONE_OVER_K16 = 16'sd19898;

  // atan(2^-i) at 16-bit angle scale; callers shift down to their word width
  function automatic logic signed [15:0] atan16(input logic [3:0] idx);
    logic signed [15:0] r;
    case (idx)
      4'd0:    r = 16'sd8192;
      4'd1:    r = 16'sd4836;
      4'd2:    r = 16'sd2555;
      4'd3:    r = 16'sd1297;
      4'd4:    r = 16'sd651;
      4'd5:    r = 16'sd326;
      4'd6:    r = 16'sd163;
      4'd7:    r = 16'sd81;
      4'd8:    r = 16'sd41;
      4'd9:    r = 16'sd20;
      4'd10:   r = 16'sd10;
      4'd11:   r = 16'sd5;
      4'd12:   r = 16'sd3;
      4'd13:   r = 16'sd1;
      4'd14:   r = 16'sd1;
      default: r = 16'sd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_digit_sipo_piso.sv
// cordic_digit_sipo_piso: one channel of serial-in word assembly plus a load-able serial-out shifter.
// Latency: a digit is visible in word_o one edge after shift_in_i; a load appears on dout_o one edge later.
// Backpressure: none; a load always overrides an in-progress shift-out and restarts at digit 0.
module cordic_digit_sipo_piso
  import cordic_pkg::*;
#(
  parameter int DIGIT_W = 2,
  parameter int WORD_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_in_i,
  input  logic [DIGIT_W-1:0] din_i,
  output logic [WORD_W-1:0]  word_o,
  input  logic               load_i,
  input  logic [WORD_W-1:0]  load_dat_i,
  input  logic               shift_out_i,
  input  logic               oen_i,
  output logic [DIGIT_W-1:0] dout_o
);

  logic [WORD_W-1:0] in_q;
  logic [WORD_W-1:0] in_d;
  logic [WORD_W-1:0] out_q;
  logic [WORD_W-1:0] out_d;

  // Serial-in: each digit enters at the top so digit 0 settles at the LSB after a full frame.
  // A restarted frame needs no clear: the full set of new digits pushes the stale ones out.
  generate
    if (WORD_W == DIGIT_W) begin : g_single_digit
      always_comb in_d = shift_in_i ? din_i : in_q;
    end else begin : g_multi_digit
      always_comb in_d = shift_in_i ? {din_i, in_q[WORD_W-1:DIGIT_W]} : in_q;
    end
  endgenerate

  // Serial-out: a fresh result wins over shifting so it always starts at digit 0.
  always_comb begin
    out_d = out_q;
    if (load_i) begin
      out_d = load_dat_i;
    end else if (shift_out_i) begin
      out_d = out_q >> DIGIT_W;
    end
  end

  // Input and output word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

  assign word_o = in_q;
  // Idle lanes are forced to zero so downstream stages never see stale digits.
  assign dout_o = oen_i ? out_q[DIGIT_W-1:0] : '0;

endmodule

// File: rtl/cordic_element_serial.sv
// cordic_element_serial: digit-serial CORDIC micro-rotation (rotation or vectoring), LSB digit first.
// Latency: rdy in cycle T -> result digit 0 with vld in cycle T+NDIG+2; compute edge ends T+NDIG+1.
// Backpressure: none; rdy mid-load restarts the load, a new result preempts shift-out. Option: CORDIC_PRESET_EN.
module cordic_element_serial
  import cordic_pkg::*;
#(
  parameter int DIGIT_W = 2,
  parameter int WORD_W  = 12,
  parameter int STG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               mode,
  input  logic [STG_W-1:0]   stg,
  input  logic [DIGIT_W-1:0] xin,
  input  logic [DIGIT_W-1:0] yin,
  input  logic [DIGIT_W-1:0] ain,
  input  logic               is_in,
  output logic [DIGIT_W-1:0] xout,
  output logic [DIGIT_W-1:0] yout,
  output logic [DIGIT_W-1:0] aout,
  output logic               is_out,
  output logic               vld,
  output logic               busy
);

  localparam int NDIG  = WORD_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  // Load-side sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;

`ifdef CORDIC_PRESET_EN
  localparam logic signed [WORD_W-1:0] ONE_OVER_K = WORD_W'(ONE_OVER_K16 >>> (16 - WORD_W));
`endif

  // Load sequencer
  logic [1:0]       st_q;
  logic [1:0]       st_d;
  logic [CNT_W-1:0] ld_cnt_q;
  logic [CNT_W-1:0] ld_cnt_d;
  logic             shift_in;
  logic             calc;

  // Output sequencer, independent of the load counter so frames can overlap
  logic             out_act_q;
  logic             out_act_d;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] out_cnt_d;
  logic             shift_out;
  logic             is_q;
  logic             is_d;

  // Datapath
  logic [WORD_W-1:0]        x_w;
  logic [WORD_W-1:0]        y_w;
  logic [WORD_W-1:0]        a_w;
  logic signed [WORD_W-1:0] x_s;
  logic signed [WORD_W-1:0] y_s;
  logic signed [WORD_W-1:0] a_s;
  logic signed [WORD_W-1:0] xsh;
  logic signed [WORD_W-1:0] ysh;
  logic signed [WORD_W-1:0] atan_w;
  logic signed [WORD_W-1:0] x_n;
  logic signed [WORD_W-1:0] y_n;
  logic signed [WORD_W-1:0] a_n;
  logic                     d_neg;

  assign x_s = x_w;
  assign y_s = y_w;
  assign a_s = a_w;

  // Load sequencing: count digits in, then spend one cycle on the compute edge.
  // rdy always wins; arriving in ST_CALC it still lets that compute happen.
  always_comb begin
    st_d     = st_q;
    ld_cnt_d = ld_cnt_q;
    shift_in = 1'b0;
    calc     = 1'b0;
    case (st_q)
      ST_LOAD: begin
        shift_in = 1'b1;
        if (ld_cnt_q == LAST_DIG) begin
          st_d     = ST_CALC;
          ld_cnt_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      ST_CALC: begin
        calc = 1'b1;
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    if (rdy) begin
      st_d     = ST_LOAD;
      ld_cnt_d = '0;
      shift_in = 1'b0;
    end
  end

  // One shift-add iteration on the assembled words; only consumed on the compute edge.
  always_comb begin
    xsh    = x_s >>> stg;
    ysh    = y_s >>> stg;
    atan_w = WORD_W'(atan16(4'(stg)) >>> (16 - WORD_W));
    case (mode)
      MODE_ROT: d_neg = a_s[WORD_W-1];
      MODE_VEC: d_neg = ~y_s[WORD_W-1];
      default:  d_neg = 1'b0;
    endcase
    x_n = d_neg ? (x_s + ysh) : (x_s - ysh);
    y_n = d_neg ? (y_s - xsh) : (y_s + xsh);
    a_n = d_neg ? (a_s + atan_w) : (a_s - atan_w);
`ifdef CORDIC_PRESET_EN
    // Stage 0 in rotation seeds the gain-compensated unit vector instead of using X/Y.
    if ((mode == MODE_ROT) && (stg == '0)) begin
      x_n = ONE_OVER_K;
      y_n = d_neg ? -ONE_OVER_K : ONE_OVER_K;
    end
`endif
  end

  // Output sequencing: shift NDIG digits after each compute; a new compute restarts at digit 0.
  always_comb begin
    out_act_d = out_act_q;
    out_cnt_d = out_cnt_q;
    shift_out = 1'b0;
    is_d      = calc ? is_in : is_q;
    if (out_act_q) begin
      shift_out = 1'b1;
      if (out_cnt_q == LAST_DIG) begin
        out_act_d = 1'b0;
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
    if (calc) begin
      out_act_d = 1'b1;
      out_cnt_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      ld_cnt_q  <= '0;
      out_act_q <= 1'b0;
      out_cnt_q <= '0;
      is_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      ld_cnt_q  <= ld_cnt_d;
      out_act_q <= out_act_d;
      out_cnt_q <= out_cnt_d;
      is_q      <= is_d;
    end
  end

  cordic_digit_sipo_piso #(.DIGIT_W(DIGIT_W), .WORD_W(WORD_W)) u_x (
    .clk        (clk),
    .rst        (rst),
    .shift_in_i (shift_in),
    .din_i      (xin),
    .word_o     (x_w),
    .load_i     (calc),
    .load_dat_i (x_n),
    .shift_out_i(shift_out),
    .oen_i      (out_act_q),
    .dout_o     (xout)
  );

  cordic_digit_sipo_piso #(.DIGIT_W(DIGIT_W), .WORD_W(WORD_W)) u_y (
    .clk        (clk),
    .rst        (rst),
    .shift_in_i (shift_in),
    .din_i      (yin),
    .word_o     (y_w),
    .load_i     (calc),
    .load_dat_i (y_n),
    .shift_out_i(shift_out),
    .oen_i      (out_act_q),
    .dout_o     (yout)
  );

  cordic_digit_sipo_piso #(.DIGIT_W(DIGIT_W), .WORD_W(WORD_W)) u_a (
    .clk        (clk),
    .rst        (rst),
    .shift_in_i (shift_in),
    .din_i      (ain),
    .word_o     (a_w),
    .load_i     (calc),
    .load_dat_i (a_n),
    .shift_out_i(shift_out),
    .oen_i      (out_act_q),
    .dout_o     (aout)
  );

  assign is_out = is_q;
  assign vld    = out_act_q && (out_cnt_q == '0);
  assign busy   = (st_q != ST_IDLE) || out_act_q;

endmodule
